// File: rtl/mem_arb_if.sv
// Bundle of the two requester ports and the memory-side strobes for mem_arb.
// The arbiter sits on the slave modport; requesters and memory sit on the master modport.
interface mem_arb_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              gnt0;
   logic              rvalid0;
   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt1;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_data_out,
      output gnt0, rvalid0, gnt1, rvalid1, rdata, busy,
      output mem_read, mem_write, mem_addr, mem_data_in
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_data_out,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata, busy,
      input  mem_read, mem_write, mem_addr, mem_data_in
   );
endinterface

// File: rtl/mem_arb.sv
// Two-requester arbiter/sequencer for a shared synchronous single-port memory.
// One access per grant: IDLE -> ACCESS (one strobe) -> RESP (reads only) -> IDLE.
module mem_arb #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   mem_arb_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              win_q, win_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              pick1;
   logic              we_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         win_q     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         win_q     <= win_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      win_d     = win_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      // Requester 1 wins alone, or on a tie when round-robin and 0 went last.
      pick1     = bus.req1 & (~bus.req0 | (~FIXED_PRIO & ~last_q));
      we_sel    = pick1 ? bus.we1 : bus.we0;

      unique case (state_q)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               win_d   = pick1;
               last_d  = pick1;
               gnt0_d  = ~pick1;
               gnt1_d  = pick1;
               rd_d    = ~we_sel;
               wr_d    = we_sel;
               addr_d  = pick1 ? bus.addr1 : bus.addr0;
               wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            rvalid0_d = rd_q & ~win_q;
            rvalid1_d = rd_q & win_q;
            state_d   = rd_q ? RESP : IDLE;
         end
         RESP: begin
            rdata_d = bus.mem_data_out;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.gnt0        = gnt0_q;
   assign bus.gnt1        = gnt1_q;
   assign bus.rvalid0     = rvalid0_q;
   assign bus.rvalid1     = rvalid1_q;
   assign bus.mem_read    = rd_q;
   assign bus.mem_write   = wr_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.busy        = (state_q != IDLE);
   // Memory output passes straight through in RESP; a copy holds it afterwards.
   assign bus.rdata       = (state_q == RESP) ? bus.mem_data_out : rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: round-robin instance plus a fixed-priority instance,
// each with a small synchronous memory model on its memory side.
module tb_mem_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   excl_viol = 0;

   logic [7:0] mem_a [32];
   logic [7:0] mem_b [32];

   mem_arb_if #(.ADDR_W(5), .DATA_W(8)) ai ();
   mem_arb_if #(.ADDR_W(5), .DATA_W(8)) bi ();

   mem_arb #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1'b0)) dut_rr (
      .clk(clk), .rst(rst), .bus(ai.slave)
   );
   mem_arb #(.ADDR_W(5), .DATA_W(8), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .rst(rst), .bus(bi.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ai.mem_write) mem_a[ai.mem_addr] <= ai.mem_data_in;
      if (ai.mem_read)  ai.mem_data_out    <= mem_a[ai.mem_addr];
      if (bi.mem_write) mem_b[bi.mem_addr] <= bi.mem_data_in;
      if (bi.mem_read)  bi.mem_data_out    <= mem_b[bi.mem_addr];
   end

   always @(negedge clk) begin
      if ((ai.mem_read & ai.mem_write) | (bi.mem_read & bi.mem_write))
         excl_viol++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input bit p, input logic req, input logic we,
                          input logic [4:0] a, input logic [7:0] d);
      if (!p) begin
         ai.req0 = req; ai.we0 = we; ai.addr0 = a; ai.wdata0 = d;
      end else begin
         ai.req1 = req; ai.we1 = we; ai.addr1 = a; ai.wdata1 = d;
      end
   endtask

   // Single-requester access on the round-robin instance; d is write data or expected read data.
   task automatic acc_a(input bit p, input logic we, input logic [4:0] a, input logic [7:0] d);
      drive_a(p, 1'b1, we, a, d);
      tick();
      chk("acc_gnt", {30'd0, ai.gnt1, ai.gnt0}, p ? 32'd2 : 32'd1);
      chk("acc_strobe", {30'd0, ai.mem_read, ai.mem_write}, we ? 32'd1 : 32'd2);
      chk("acc_addr", {27'd0, ai.mem_addr}, {27'd0, a});
      chk("acc_busy", {31'd0, ai.busy}, 32'd1);
      if (we) chk("acc_wdata", {24'd0, ai.mem_data_in}, {24'd0, d});
      drive_a(p, 1'b0, 1'b0, '0, '0);
      tick();
      if (!we) begin
         chk("acc_rvalid", {30'd0, ai.rvalid1, ai.rvalid0}, p ? 32'd2 : 32'd1);
         chk("acc_rdata", {24'd0, ai.rdata}, {24'd0, d});
         tick();
         chk("acc_rdhold", {24'd0, ai.rdata}, {24'd0, d});
      end
      chk("acc_idle", {27'd0, ai.busy, ai.rvalid1, ai.rvalid0, ai.gnt1, ai.gnt0}, 32'd0);
   endtask

   // Both ports read continuously; grants must alternate starting from 'first'.
   task automatic tie_reads(input int n, input bit first, input logic [4:0] a0, input logic [7:0] d0,
                            input logic [4:0] a1, input logic [7:0] d1);
      bit w;
      drive_a(1'b0, 1'b1, 1'b0, a0, '0);
      drive_a(1'b1, 1'b1, 1'b0, a1, '0);
      for (int k = 0; k < n; k++) begin
         w = first ^ k[0];
         tick();
         chk("tie_gnt", {30'd0, ai.gnt1, ai.gnt0}, w ? 32'd2 : 32'd1);
         chk("tie_strobe", {30'd0, ai.mem_read, ai.mem_write}, 32'd2);
         tick();
         chk("tie_rvalid", {30'd0, ai.rvalid1, ai.rvalid0}, w ? 32'd2 : 32'd1);
         chk("tie_rdata", {24'd0, ai.rdata}, w ? {24'd0, d1} : {24'd0, d0});
         if (k == n - 1) begin
            drive_a(1'b0, 1'b0, 1'b0, '0, '0);
            drive_a(1'b1, 1'b0, 1'b0, '0, '0);
         end
         tick();
      end
   endtask

   initial begin
      drive_a(1'b0, 1'b0, 1'b0, '0, '0);
      drive_a(1'b1, 1'b0, 1'b0, '0, '0);
      bi.req0 = 1'b0; bi.we0 = 1'b0; bi.addr0 = '0; bi.wdata0 = '0;
      bi.req1 = 1'b0; bi.we1 = 1'b0; bi.addr1 = '0; bi.wdata1 = '0;
      tick();
      tick();
      chk("rst_ctl_a", {25'd0, ai.gnt0, ai.gnt1, ai.rvalid0, ai.rvalid1, ai.busy, ai.mem_read, ai.mem_write}, 32'd0);
      chk("rst_bus_a", {8'd0, ai.mem_addr, ai.mem_data_in, ai.rdata}, 32'd0);
      chk("rst_ctl_b", {25'd0, bi.gnt0, bi.gnt1, bi.rvalid0, bi.rvalid1, bi.busy, bi.mem_read, bi.mem_write}, 32'd0);
      rst = 1'b0;
      tick();

      // Write A5 to 3 then read it back on port 0.
      acc_a(1'b0, 1'b1, 5'd3, 8'hA5);
      chk("mem3", {24'd0, mem_a[3]}, 32'hA5);
      acc_a(1'b0, 1'b0, 5'd3, 8'hA5);

      // Port 1 write leaves last=1, so the tie sequence starts with port 0.
      acc_a(1'b1, 1'b1, 5'd7, 8'h3C);
      tie_reads(4, 1'b0, 5'd3, 8'hA5, 5'd7, 8'h3C);

      // Fixed-priority instance: port 0 wins every tie until it drops.
      bi.req0 = 1'b1; bi.we0 = 1'b1; bi.addr0 = 5'd1; bi.wdata0 = 8'h11;
      bi.req1 = 1'b1; bi.we1 = 1'b1; bi.addr1 = 5'd2; bi.wdata1 = 8'h22;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fp_gnt0", {30'd0, bi.gnt1, bi.gnt0}, 32'd1);
         chk("fp_addr0", {27'd0, bi.mem_addr}, 32'd1);
         if (k == 2) bi.req0 = 1'b0;
         tick();
      end
      tick();
      chk("fp_gnt1", {30'd0, bi.gnt1, bi.gnt0}, 32'd2);
      chk("fp_addr1", {27'd0, bi.mem_addr}, 32'd2);
      bi.req1 = 1'b0;
      tick();
      chk("fp_mem1", {24'd0, mem_b[1]}, 32'h11);
      chk("fp_mem2", {24'd0, mem_b[2]}, 32'h22);

      // Loader fills all 32 locations through port 1, CPU reads the top one.
      for (int i = 0; i < 32; i++) acc_a(1'b1, 1'b1, i[4:0], i[7:0]);
      acc_a(1'b0, 1'b0, 5'd31, 8'd31);

      // Reset lands in the RESP cycle of a port-0 read.
      drive_a(1'b0, 1'b1, 1'b0, 5'd10, '0);
      tick();
      drive_a(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("pre_rst_rvalid", {31'd0, ai.rvalid0}, 32'd1);
      chk("pre_rst_rdata", {24'd0, ai.rdata}, 32'd10);
      rst = 1'b1;
      #1;
      chk("mid_rst_ctl", {25'd0, ai.gnt0, ai.gnt1, ai.rvalid0, ai.rvalid1, ai.busy, ai.mem_read, ai.mem_write}, 32'd0);
      chk("mid_rst_bus", {8'd0, ai.mem_addr, ai.mem_data_in, ai.rdata}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_rvalid", {30'd0, ai.rvalid1, ai.rvalid0}, 32'd0);
      tie_reads(2, 1'b0, 5'd10, 8'd10, 5'd31, 8'd31);

      // Port 0 goes last, then ten idle cycles must not rotate the pointer.
      acc_a(1'b0, 1'b0, 5'd5, 8'd5);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_busy", {31'd0, ai.busy}, 32'd0);
         chk("idle_strobe", {30'd0, ai.mem_read, ai.mem_write}, 32'd0);
      end
      tie_reads(2, 1'b1, 5'd10, 8'd10, 5'd31, 8'd31);

      chk("mutex", excl_viol, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
